// File: rtl/ddr2_burst_writer.sv
// ddr2_burst_writer: moves BURST_LEN-word blocks from the input FIFO into MIG port 0, one write command per burst.
// Define BURST_WR_ERR_CHECK_EN to build the sticky protocol error flag; otherwise err is tied low.
module ddr2_burst_writer #(
  parameter int          BURST_LEN  = 32,
  parameter logic [29:0] ADDR_LIMIT = 30'h0400_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        writes_en,
  input  logic        calib_done,
  output logic        ib_re,
  input  logic [31:0] ib_data,
  input  logic        ib_valid,
  input  logic [9:0]  ib_count,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  input  logic        wr_full,
  input  logic        wr_empty,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        busy,
  output logic [15:0] burst_cnt,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, CMD} state_t;
  localparam logic [30:0] STEP = 31'(BURST_LEN * 4);
  localparam logic [6:0]  BL   = 7'(BURST_LEN);
  state_t      r_state;
  logic [6:0]  r_rd_cnt, r_wr_cnt;
  logic [29:0] r_addr, r_cmd_addr;
  logic [31:0] r_wr_data;
  logic [15:0] r_burst_cnt;
  logic        r_ib_re, r_wr_en, r_cmd_en;
  logic [30:0] w_next;
  logic        w_start, w_issue;
  assign w_next  = {1'b0, r_addr} + STEP;
  assign w_start = calib_done & writes_en & wr_empty & (ib_count >= 10'(BURST_LEN));
  // cmd_full is sampled one cycle ahead so cmd_en can be registered yet land in the first CMD cycle
  assign w_issue = !cmd_full && ((r_state == DRAIN && r_wr_cnt == BL) || (r_state == CMD && !r_cmd_en));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_addr      <= '0;
      r_cmd_addr  <= '0;
      r_wr_data   <= '0;
      r_burst_cnt <= '0;
      r_ib_re     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_cmd_en    <= 1'b0;
    end else begin
      r_wr_en  <= 1'b0;
      r_cmd_en <= w_issue;
      if (w_issue) begin
        r_cmd_addr  <= r_addr;
        r_addr      <= (w_next >= {1'b0, ADDR_LIMIT}) ? '0 : w_next[29:0];
        r_burst_cnt <= r_burst_cnt + 16'd1;
      end
      if ((r_state == FILL || r_state == DRAIN) && ib_valid) begin
        r_wr_en   <= 1'b1;
        r_wr_data <= ib_data;
        r_wr_cnt  <= r_wr_cnt + 7'd1;
      end
      case (r_state)
        IDLE: if (w_start) begin
          r_state  <= FILL;
          r_ib_re  <= 1'b1;
          r_rd_cnt <= '0;
          r_wr_cnt <= '0;
        end
        FILL: begin
          r_rd_cnt <= r_rd_cnt + 7'd1;
          r_ib_re  <= (r_rd_cnt + 7'd1 < BL);
          if (r_rd_cnt + 7'd1 == BL) r_state <= DRAIN;
        end
        DRAIN: if (r_wr_cnt == BL) r_state <= CMD;
        CMD: if (r_cmd_en) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef BURST_WR_ERR_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else if ((wr_full && r_wr_en) || (ib_valid && (r_state == IDLE || r_state == CMD))) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  logic w_unused;
  assign w_unused = wr_full;
  assign err = 1'b0;
`endif
  assign ib_re         = r_ib_re;
  assign wr_en         = r_wr_en;
  assign wr_data       = r_wr_data;
  assign wr_mask       = 4'b0000;
  assign cmd_en        = r_cmd_en;
  assign cmd_instr     = 3'b000;
  assign cmd_bl        = 6'(BURST_LEN - 1);
  assign cmd_byte_addr = r_cmd_addr;
  assign busy          = (r_state != IDLE);
  assign burst_cnt     = r_burst_cnt;
endmodule

// File: tb/tb_ddr2_burst_writer.sv
// tb_ddr2_burst_writer: directed bench with an input FIFO model and data/command scoreboards.
module tb_ddr2_burst_writer;
  localparam int BL = 32;
  logic        clk = 0, reset = 0, writes_en = 0, calib_done = 0;
  logic        ib_valid = 0, wr_full = 0, wr_empty = 1, cmd_full = 0;
  logic [31:0] ib_data = 0;
  logic [9:0]  ib_count = 0;
  logic        ib_re, wr_en, cmd_en, busy, err;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic [15:0] burst_cnt;
  int errors = 0, checks = 0;
  int n_wr = 0, n_cmd = 0, cyc = 0, t_re = 0, t_cmd = 0;
  logic prev_re = 0, fifo_re = 0;
  logic [31:0] in_q[$], exp_q[$];
  logic [29:0] addr_q[$];

  ddr2_burst_writer #(.BURST_LEN(BL), .ADDR_LIMIT(30'h180)) dut (
    .clk(clk), .reset(reset), .writes_en(writes_en), .calib_done(calib_done),
    .ib_re(ib_re), .ib_data(ib_data), .ib_valid(ib_valid), .ib_count(ib_count),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full), .wr_empty(wr_empty),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_full(cmd_full), .busy(busy), .burst_cnt(burst_cnt), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] base, input int n, input int n_exp);
    for (int i = 0; i < n; i++) begin
      in_q.push_back(base + 32'(i));
      if (i < n_exp) exp_q.push_back(base + 32'(i));
    end
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 0;
    repeat (n) begin @(negedge clk); seen |= ib_re | busy; end
    chk(tag, 32'(seen), 0);
  endtask

  task automatic wait_re(input logic lvl);
    int k;
    k = 0;
    while (ib_re !== lvl && k < 100) begin @(negedge clk); k++; end
    chk("wait_re", 32'(ib_re), 32'(lvl));
  endtask

  task automatic wait_bursts(input int n);
    int k;
    k = 0;
    while (burst_cnt !== 16'(n) && k < 500) begin @(negedge clk); k++; end
    chk("burst_done", 32'(burst_cnt), 32'(n));
  endtask

  // input FIFO: data appears one cycle after the strobe
  initial forever begin
    @(negedge clk);
    fifo_re = ib_re;
    @(posedge clk);
    #1;
    ib_valid = fifo_re && in_q.size() > 0;
    if (ib_valid) ib_data = in_q.pop_front();
    ib_count = 10'(in_q.size());
  end

  always @(negedge clk) begin
    cyc++;
    if (ib_re && !prev_re) t_re = cyc;
    prev_re = ib_re;
    if (wr_en) begin
      n_wr++;
      chk("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("wr_data", wr_data, exp_q.pop_front());
      chk("wr_mask", 32'(wr_mask), 0);
    end
    if (cmd_en) begin
      n_cmd++;
      t_cmd = cyc;
      chk("cmd_expected", 32'(addr_q.size() != 0), 1);
      if (addr_q.size() != 0) chk("cmd_addr", 32'(cmd_byte_addr), 32'(addr_q.pop_front()));
      chk("cmd_bl", 32'(cmd_bl), BL - 1);
      chk("cmd_instr", 32'(cmd_instr), 0);
    end
  end

  initial begin
    #1 reset = 1;
    tick(2);
    chk("rst_ib_re", 32'(ib_re), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cmd_en", 32'(cmd_en), 0);
    chk("rst_addr", 32'(cmd_byte_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(burst_cnt), 0);
    chk("rst_err", 32'(err), 0);
    reset = 0;
    calib_done = 1;
    // burst 1
    load(32'h1000, BL, BL);
    addr_q.push_back(30'h0);
    writes_en = 1;
    wait_bursts(1);
    tick(2);
    chk("b1_words", n_wr, 32);
    chk("b1_cmds", n_cmd, 1);
    chk("b1_latency", t_cmd - t_re, BL + 2);
    chk("b1_idle", 32'(busy), 0);
    chk("b1_drained", exp_q.size(), 0);
    // burst 2: 31 words must not start, the 32nd starts it
    load(32'h2000, BL - 1, BL - 1);
    quiet("gate_count", 6);
    addr_q.push_back(30'h80);
    load(32'h201F, 1, 1);
    tick(1);
    chk("start_early", 32'(ib_re), 0);
    tick(1);
    chk("start_next", 32'(ib_re), 1);
    wait_bursts(2);
    tick(2);
    chk("b2_words", n_wr, 64);
    chk("b2_cmds", n_cmd, 2);
    // burst 3: blocked by wr_empty, then held in CMD by cmd_full
    wr_empty = 0;
    cmd_full = 1;
    load(32'h3000, BL, BL);
    addr_q.push_back(30'h100);
    quiet("gate_empty", 6);
    wr_empty = 1;
    tick(1);
    chk("empty_start", 32'(ib_re), 1);
    for (int k = 0; k < 200 && n_wr < 96; k++) tick(1);
    chk("b3_words", n_wr, 96);
    begin
      logic seen_cmd, seen_idle, addr_moved;
      seen_cmd = 0; seen_idle = 0; addr_moved = 0;
      repeat (10) begin
        @(negedge clk);
        seen_cmd |= cmd_en;
        seen_idle |= !busy;
        addr_moved |= (cmd_byte_addr !== 30'h80);
      end
      chk("hold_no_cmd", 32'(seen_cmd), 0);
      chk("hold_busy", 32'(seen_idle), 0);
      chk("hold_addr", 32'(addr_moved), 0);
    end
    cmd_full = 0;
    wait_bursts(3);
    tick(3);
    chk("b3_cmds", n_cmd, 3);
    chk("b3_idle", 32'(busy), 0);
    // burst 4: writes_en dropped mid-FILL, address wraps
    load(32'h4000, 2 * BL, BL);
    addr_q.push_back(30'h0);
    wait_re(1);
    tick(10);
    writes_en = 0;
    wait_bursts(4);
    tick(2);
    quiet("drop_idle", 8);
    chk("b4_words", n_wr, 128);
    chk("b4_cmds", n_cmd, 4);
    chk("b4_left", 32'(ib_count), 32);
    // burst 5: reset in DRAIN
    for (int i = 0; i < BL; i++) exp_q.push_back(32'h4020 + 32'(i));
    writes_en = 1;
    wait_re(1);
    wait_re(0);
    tick(1);
    #2 reset = 1;
    #1;
    chk("mid_wr_en", 32'(wr_en), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_cnt", 32'(burst_cnt), 0);
    chk("mid_addr", 32'(cmd_byte_addr), 0);
    chk("mid_words", n_wr, 160);
    chk("mid_cmds", n_cmd, 4);
    @(negedge clk);
    reset = 0;
    // burst 6: restarts at address 0, wr_full forced
    load(32'h5000, BL, BL);
    addr_q.push_back(30'h0);
    wr_full = 1;
    wait_bursts(1);
    tick(2);
    wr_full = 0;
    chk("b6_words", n_wr, 192);
    chk("b6_cmds", n_cmd, 5);
    tick(3);
`ifdef BURST_WR_ERR_CHECK_EN
    chk("err_sticky", 32'(err), 1);
`else
    chk("err_off", 32'(err), 0);
`endif
    reset = 1;
    #1;
    chk("err_clear", 32'(err), 0);
    chk("final_cnt", 32'(burst_cnt), 0);
    @(negedge clk);
    reset = 0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
